iso_alu_scheduler: RTL

//   Shares one operand-isolated ALU (mul/add/div/sub, 4-bit operands, registered 8-bit result)

---
 rtl/iso_alu_scheduler_pkg.sv | 39 +++
 rtl/iso_alu_scheduler_if.sv | 36 +++
 rtl/iso_alu_scheduler_rr_arbiter.sv | 44 ++++
 rtl/iso_alu_scheduler.sv | 107 ++++++++++
 4 files changed

// File: rtl/iso_alu_scheduler_pkg.sv
// Shared encodings for the isolated-ALU scheduler: op codes, one-hot ALU selects,
// FSM states and the op-to-select mapping.
package iso_alu_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_ADD = 2'd1,
    OP_DIV = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  // sel1 (mul) is the MSB of alu_sel
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_MUL  = 4'b1000;
  localparam logic [3:0] SEL_ADD  = 4'b0100;
  localparam logic [3:0] SEL_DIV  = 4'b0010;
  localparam logic [3:0] SEL_SUB  = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  function automatic logic [3:0] op2sel(input op_e op);
    logic [3:0] sel;
    sel = SEL_NONE;
    unique case (op)
      OP_MUL: sel = SEL_MUL;
      OP_ADD: sel = SEL_ADD;
      OP_DIV: sel = SEL_DIV;
      OP_SUB: sel = SEL_SUB;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/iso_alu_scheduler_if.sv
// Request, ALU and response signals of the scheduler. The slave modport is the
// scheduler's view; master is the requester/ALU/consumer side.
interface iso_alu_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][1:0]        req_op;
  logic [NREQ-1:0][WIDTH-1:0]  req_a;
  logic [NREQ-1:0][WIDTH-1:0]  req_b;
  logic [NREQ-1:0]             req_ready;

  logic [3:0]                  alu_sel;
  logic [WIDTH-1:0]            alu_a;
  logic [WIDTH-1:0]            alu_b;
  logic [2*WIDTH-1:0]          alu_out;

  logic                        rsp_valid;
  logic [IW-1:0]               rsp_id;
  logic [2*WIDTH-1:0]          rsp_data;
  logic                        rsp_ready;
  logic                        busy;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
    input  req_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
    output req_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/iso_alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer (wrapping)
// and moves the pointer one past the winner when the grant is taken.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [IW-1:0] ptr_q;
  logic [IW:0]   k;

  // one extra bit on k keeps ptr+i from overflowing before the wrap
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = {1'b0, ptr_q} + (IW+1)'(i);
      if (k >= (IW+1)'(NREQ)) k = k - (IW+1)'(NREQ);
      if (!gnt_any && req[k[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = k[IW-1:0];
      end
    end
  end

  assign gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (advance && gnt_any) begin
      ptr_q <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/iso_alu_scheduler.sv
// Shares one operand-isolated ALU between NREQ requesters: round-robin grant,
// one transaction in flight, multi-cycle divide, div-by-zero bypass, valid/ready response.
module iso_alu_scheduler
  import iso_alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int DIV_LAT = 3
) (
  input logic                clk,
  input logic                rst,
  iso_alu_scheduler_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] DIV_HOLD = CW'(DIV_LAT - 1);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               take;
  logic               div_zero;
  op_e                gnt_op;

  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IW-1:0]      id_q;
  logic [CW-1:0]      lat_q;
  logic [2*WIDTH-1:0] data_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // rst gates the accept pulse so req_ready is 0 while reset is held
  assign take     = (state_q == S_IDLE) && gnt_any && rst;
  assign gnt_op   = op_e'(bus.req_op[gnt_idx]);
  assign div_zero = (gnt_op == OP_DIV) && (bus.req_b[gnt_idx] == '0);

  assign bus.req_ready = take ? gnt : '0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // operands reach the ALU only in ISSUE; every other state isolates it at zero
  always_comb begin
    state_d       = state_q;
    bus.alu_sel   = SEL_NONE;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take) state_d = div_zero ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        bus.alu_sel = op2sel(op_q);
        bus.alu_a   = a_q;
        bus.alu_b   = b_q;
        if (lat_q == '0) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      lat_q  <= '0;
      data_q <= '0;
    end else begin
      if (take) begin
        op_q  <= gnt_op;
        a_q   <= bus.req_a[gnt_idx];
        b_q   <= bus.req_b[gnt_idx];
        id_q  <= gnt_idx;
        lat_q <= (gnt_op == OP_DIV) ? DIV_HOLD : '0;
        if (div_zero) data_q <= '1;
      end else if (state_q == S_ISSUE && lat_q != '0) begin
        lat_q <= lat_q - CW'(1);
      end
      if (state_q == S_CAPTURE) data_q <= bus.alu_out;
    end
  end

endmodule
